// File: rtl/xillybus_apfifo_bridge_if.sv
// Xillybus user-side FIFO ports and HLS ap_fifo accelerator ports for NCH channels.
interface xillybus_apfifo_bridge_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DW    = 128,
  parameter int unsigned DEPTH = 512
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  // Host write side (H2A fill)
  logic [NCH-1:0]    user_w_open;
  logic [NCH-1:0]    user_w_wren;
  logic [NCH*DW-1:0] user_w_data;
  logic [NCH-1:0]    user_w_full;
  // Host read side (A2H drain)
  logic [NCH-1:0]    user_r_open;
  logic [NCH-1:0]    user_r_rden;
  logic [NCH*DW-1:0] user_r_data;
  logic [NCH-1:0]    user_r_empty;
  logic [NCH-1:0]    user_r_eof;
  // Accelerator input stream (H2A drain, first-word fall-through)
  logic [NCH*DW-1:0] acc_dout;
  logic [NCH-1:0]    acc_empty_n;
  logic [NCH-1:0]    acc_read;
  // Accelerator output stream (A2H fill)
  logic [NCH*DW-1:0] acc_din;
  logic [NCH-1:0]    acc_full_n;
  logic [NCH-1:0]    acc_write;
  logic [NCH-1:0]    acc_done;
  // Status
  logic [NCH*LW-1:0] h2a_level;
  logic [NCH*LW-1:0] a2h_level;
  logic [NCH-1:0]    ovf_flag;

  modport master (
    output user_w_open, user_w_wren, user_w_data,
    output user_r_open, user_r_rden,
    output acc_read, acc_din, acc_write, acc_done,
    input  user_w_full, user_r_data, user_r_empty, user_r_eof,
    input  acc_dout, acc_empty_n, acc_full_n,
    input  h2a_level, a2h_level, ovf_flag
  );

  modport slave (
    input  user_w_open, user_w_wren, user_w_data,
    input  user_r_open, user_r_rden,
    input  acc_read, acc_din, acc_write, acc_done,
    output user_w_full, user_r_data, user_r_empty, user_r_eof,
    output acc_dout, acc_empty_n, acc_full_n,
    output h2a_level, a2h_level, ovf_flag
  );
endinterface

// File: rtl/xillybus_apfifo_bridge.sv
// Per-channel H2A/A2H FIFO pair between Xillybus user FIFOs and ap_fifo accelerator ports.
module xillybus_apfifo_bridge #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DW    = 128,
  parameter int unsigned DEPTH = 512
) (
  input  logic                     bus_clk,
  input  logic                     bus_rst,
  xillybus_apfifo_bridge_if.slave  xb
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [NCH-1:0] w_open_q;
  logic [NCH-1:0] r_open_q;

  // Edge-detect copies of the open lines; they keep tracking through reset so a file held open does not flush afterwards
  always_ff @(posedge bus_clk) begin
    w_open_q <= xb.user_w_open;
    r_open_q <= xb.user_r_open;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DW-1:0] h_mem [DEPTH];
    logic [DW-1:0] a_mem [DEPTH];
    logic [AW-1:0] h_wp, h_rp, a_wp, a_rp;
    logic [LW-1:0] h_cnt, a_cnt;
    logic [DW-1:0] r_data;
    logic          eof_pending;
    logic          ovf;
    logic          h_full, h_nempty, a_full, a_nempty;
    logic          h_flush, a_flush;
    logic          h_push, h_pop, a_push, a_pop;

    assign h_full   = (h_cnt == LW'(DEPTH));
    assign h_nempty = (h_cnt != '0);
    assign a_full   = (a_cnt == LW'(DEPTH));
    assign a_nempty = (a_cnt != '0);

    assign h_flush  = xb.user_w_open[c] & ~w_open_q[c];
    assign a_flush  = ~xb.user_r_open[c] & r_open_q[c];

    assign h_push   = xb.user_w_wren[c] & ~h_full   & ~h_flush;
    assign h_pop    = xb.acc_read[c]    & h_nempty  & ~h_flush;
    assign a_push   = xb.acc_write[c]   & ~a_full   & ~a_flush;
    assign a_pop    = xb.user_r_rden[c] & a_nempty  & ~a_flush;

    // H2A pointers and occupancy; a flush empties the FIFO ahead of any push/pop
    always_ff @(posedge bus_clk) begin
      if (bus_rst || h_flush) begin
        h_wp  <= '0;
        h_rp  <= '0;
        h_cnt <= '0;
      end else begin
        if (h_push) h_wp <= h_wp + AW'(1);
        if (h_pop)  h_rp <= h_rp + AW'(1);
        h_cnt <= h_cnt + LW'(h_push) - LW'(h_pop);
      end
    end

    // H2A storage
    always_ff @(posedge bus_clk) begin
      if (h_push) h_mem[h_wp] <= xb.user_w_data[c*DW +: DW];
    end

    // A2H pointers and occupancy; closing the read file empties the FIFO
    always_ff @(posedge bus_clk) begin
      if (bus_rst || a_flush) begin
        a_wp  <= '0;
        a_rp  <= '0;
        a_cnt <= '0;
      end else begin
        if (a_push) a_wp <= a_wp + AW'(1);
        if (a_pop)  a_rp <= a_rp + AW'(1);
        a_cnt <= a_cnt + LW'(a_push) - LW'(a_pop);
      end
    end

    // A2H storage
    always_ff @(posedge bus_clk) begin
      if (a_push) a_mem[a_wp] <= xb.acc_din[c*DW +: DW];
    end

    // Host read data: one-cycle read latency, holds between reads
    always_ff @(posedge bus_clk) begin
      if (bus_rst)    r_data <= '0;
      else if (a_pop) r_data <= a_mem[a_rp];
    end

    // End-of-stream latch, released only by read-side flush or reset
    always_ff @(posedge bus_clk) begin
      if (bus_rst || a_flush)   eof_pending <= 1'b0;
      else if (xb.acc_done[c])  eof_pending <= 1'b1;
    end

    // Sticky overflow: a write or push was attempted into a full FIFO
    always_ff @(posedge bus_clk) begin
      if (bus_rst) ovf <= 1'b0;
      else if ((xb.user_w_wren[c] & h_full) | (xb.acc_write[c] & a_full)) ovf <= 1'b1;
    end

    assign xb.user_w_full[c]          = h_full;
    assign xb.acc_empty_n[c]          = h_nempty;
    assign xb.acc_dout[c*DW +: DW]    = h_mem[h_rp];
    assign xb.acc_full_n[c]           = ~a_full;
    assign xb.user_r_empty[c]         = ~a_nempty;
    assign xb.user_r_eof[c]           = eof_pending & ~a_nempty;
    assign xb.user_r_data[c*DW +: DW] = r_data;
    assign xb.h2a_level[c*LW +: LW]   = h_cnt;
    assign xb.a2h_level[c*LW +: LW]   = a_cnt;
    assign xb.ovf_flag[c]             = ovf;
  end
endmodule

// File: tb/tb_xillybus_apfifo_bridge.sv
// Scoreboard bench for xillybus_apfifo_bridge: queue-based reference model, directed scenarios plus random traffic.
module tb_xillybus_apfifo_bridge;
  localparam int unsigned NCH   = 4;
  localparam int unsigned DW    = 128;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LW    = AW + 1;

  typedef logic [DW-1:0] word_t;

  typedef struct packed {
    logic [NCH-1:0]    w_full;
    logic [NCH-1:0]    acc_empty_n;
    logic [NCH-1:0]    acc_full_n;
    logic [NCH-1:0]    r_empty;
    logic [NCH-1:0]    r_eof;
    logic [NCH-1:0]    ovf;
    logic [NCH*LW-1:0] h_lvl;
    logic [NCH*LW-1:0] a_lvl;
    logic [NCH*DW-1:0] rdata;
  } snap_t;

  logic bus_clk;
  logic bus_rst;

  xillybus_apfifo_bridge_if #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) xb ();

  xillybus_apfifo_bridge #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
    .bus_clk (bus_clk),
    .bus_rst (bus_rst),
    .xb      (xb)
  );

  initial begin
    bus_clk = 1'b0;
    forever #5 bus_clk = ~bus_clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain queues of words per FIFO
  word_t h_q     [NCH][$];
  word_t a_q     [NCH][$];
  word_t exp_acc [NCH][$];
  word_t exp_rd  [NCH][$];
  bit    eof_m   [NCH];
  bit    ovf_m   [NCH];
  word_t rdata_m [NCH];
  bit    w_prev  [NCH];
  bit    r_prev  [NCH];
  snap_t snap_q  [$];
  bit    rd_due  [NCH];

  task automatic check(input string name, input int c, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s ch%0d: got %0h expected %0h at %0t", name, c, act, exp, $time);
    end
  endtask

  // Model: record expected outputs for the current state, then apply this cycle's inputs
  always @(negedge bus_clk) begin
    snap_t s;
    bit w_fl, r_fl, hp, hu, ap, au;
    s = '0;
    for (int c = 0; c < NCH; c++) begin
      s.w_full[c]           = (h_q[c].size() == DEPTH);
      s.acc_empty_n[c]      = (h_q[c].size() != 0);
      s.acc_full_n[c]       = (a_q[c].size() != DEPTH);
      s.r_empty[c]          = (a_q[c].size() == 0);
      s.r_eof[c]            = eof_m[c] && (a_q[c].size() == 0);
      s.ovf[c]              = ovf_m[c];
      s.h_lvl[c*LW +: LW]   = LW'(h_q[c].size());
      s.a_lvl[c*LW +: LW]   = LW'(a_q[c].size());
      s.rdata[c*DW +: DW]   = rdata_m[c];
    end
    snap_q.push_back(s);
    for (int c = 0; c < NCH; c++) begin
      if (bus_rst) begin
        h_q[c].delete();
        a_q[c].delete();
        eof_m[c]   = 1'b0;
        ovf_m[c]   = 1'b0;
        rdata_m[c] = '0;
      end else begin
        w_fl = xb.user_w_open[c] && !w_prev[c];
        r_fl = !xb.user_r_open[c] && r_prev[c];
        hp   = xb.acc_read[c] && (h_q[c].size() != 0);
        hu   = xb.user_w_wren[c] && (h_q[c].size() != DEPTH);
        ap   = xb.user_r_rden[c] && (a_q[c].size() != 0);
        au   = xb.acc_write[c] && (a_q[c].size() != DEPTH);
        if (hp) exp_acc[c].push_back(h_q[c][0]);
        if ((xb.user_w_wren[c] && !hu) || (xb.acc_write[c] && !au)) ovf_m[c] = 1'b1;
        if (w_fl) h_q[c].delete();
        else begin
          if (hp) void'(h_q[c].pop_front());
          if (hu) h_q[c].push_back(xb.user_w_data[c*DW +: DW]);
        end
        if (r_fl) begin
          a_q[c].delete();
          eof_m[c] = 1'b0;
        end else begin
          if (ap) begin
            rdata_m[c] = a_q[c][0];
            exp_rd[c].push_back(a_q[c][0]);
            void'(a_q[c].pop_front());
          end
          if (au) a_q[c].push_back(xb.acc_din[c*DW +: DW]);
          if (xb.acc_done[c]) eof_m[c] = 1'b1;
        end
      end
      w_prev[c] = xb.user_w_open[c];
      r_prev[c] = xb.user_r_open[c];
    end
  end

  // Monitor: compare status every cycle, pop data expectations when the DUT presents a word
  always @(negedge bus_clk) begin
    snap_t s;
    #1;
    if (snap_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL snapshot: got none expected one at %0t", $time);
    end else begin
      s = snap_q.pop_front();
      check("user_w_full",  -1, 512'(xb.user_w_full),  512'(s.w_full));
      check("acc_empty_n",  -1, 512'(xb.acc_empty_n),  512'(s.acc_empty_n));
      check("acc_full_n",   -1, 512'(xb.acc_full_n),   512'(s.acc_full_n));
      check("user_r_empty", -1, 512'(xb.user_r_empty), 512'(s.r_empty));
      check("user_r_eof",   -1, 512'(xb.user_r_eof),   512'(s.r_eof));
      check("ovf_flag",     -1, 512'(xb.ovf_flag),     512'(s.ovf));
      check("h2a_level",    -1, 512'(xb.h2a_level),    512'(s.h_lvl));
      check("a2h_level",    -1, 512'(xb.a2h_level),    512'(s.a_lvl));
      check("user_r_data",  -1, 512'(xb.user_r_data),  512'(s.rdata));
    end
    for (int c = 0; c < NCH; c++) begin
      if (rd_due[c]) begin
        if (exp_rd[c].size() == 0)
          check("rd_word_unexpected", c, 512'(1), 512'(0));
        else
          check("rd_word", c, 512'(xb.user_r_data[c*DW +: DW]), 512'(exp_rd[c].pop_front()));
      end
      rd_due[c] = !bus_rst && xb.user_r_rden[c] && !xb.user_r_empty[c];
      if (!bus_rst && xb.acc_read[c] && xb.acc_empty_n[c]) begin
        if (exp_acc[c].size() == 0)
          check("acc_word_unexpected", c, 512'(1), 512'(0));
        else
          check("acc_word", c, 512'(xb.acc_dout[c*DW +: DW]), 512'(exp_acc[c].pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic idle();
    xb.user_w_wren = '0;
    xb.user_r_rden = '0;
    xb.acc_read    = '0;
    xb.acc_write   = '0;
    xb.acc_done    = '0;
  endtask

  function automatic word_t rword();
    word_t w;
    for (int i = 0; i < int'(DW / 32); i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic random_cycle(input int unsigned wr_pct, input int unsigned rd_pct);
    bit fall;
    idle();
    for (int c = 0; c < NCH; c++) begin
      fall = 1'b0;
      if ($urandom_range(0, 199) == 0) xb.user_w_open[c] = ~xb.user_w_open[c];
      if ($urandom_range(0, 199) == 0) begin
        fall = xb.user_r_open[c];
        xb.user_r_open[c] = ~xb.user_r_open[c];
      end
      xb.user_w_wren[c]            = ($urandom_range(0, 99) < wr_pct);
      xb.user_w_data[c*DW +: DW]   = rword();
      xb.acc_read[c]               = ($urandom_range(0, 99) < rd_pct);
      xb.acc_write[c]              = ($urandom_range(0, 99) < wr_pct);
      xb.acc_din[c*DW +: DW]       = rword();
      xb.user_r_rden[c]            = xb.user_r_open[c] && ($urandom_range(0, 99) < rd_pct);
      xb.acc_done[c]               = !fall && ($urandom_range(0, 59) == 0);
    end
    tick();
  endtask

  // Driver
  initial begin
    int unsigned wp, rp;
    bus_rst        = 1'b1;
    xb.user_w_open = '0;
    xb.user_r_open = '0;
    xb.user_w_data = '0;
    xb.acc_din     = '0;
    idle();
    repeat (3) tick();
    bus_rst        = 1'b0;
    xb.user_w_open = '1;
    xb.user_r_open = '1;
    tick();

    // ch0 H2A: three words, then three accelerator reads
    for (int i = 1; i <= 3; i++) begin
      xb.user_w_wren[0] = 1'b1;
      xb.user_w_data[0 +: DW] = word_t'(i);
      tick();
    end
    idle();
    tick();
    xb.acc_read[0] = 1'b1;
    repeat (3) tick();
    idle();
    tick();

    // ch1 H2A: fill to DEPTH plus one dropped word, then drain
    for (int i = 0; i <= int'(DEPTH); i++) begin
      xb.user_w_wren[1] = 1'b1;
      xb.user_w_data[1*DW +: DW] = word_t'(i);
      tick();
    end
    idle();
    tick();
    xb.acc_read[1] = 1'b1;
    repeat (DEPTH + 2) tick();
    idle();
    tick();

    // ch2 A2H: two pushes with done on the last, then two reads
    xb.acc_write[2] = 1'b1;
    xb.acc_din[2*DW +: DW] = word_t'(32'hA);
    tick();
    xb.acc_din[2*DW +: DW] = word_t'(32'hB);
    xb.acc_done[2] = 1'b1;
    tick();
    idle();
    repeat (2) tick();
    for (int i = 0; i < 2; i++) begin
      xb.user_r_rden[2] = 1'b1;
      tick();
      idle();
      tick();
    end
    repeat (2) tick();

    // ch3 A2H: hold level 5 with simultaneous push and read
    for (int i = 0; i < 5; i++) begin
      xb.acc_write[3] = 1'b1;
      xb.acc_din[3*DW +: DW] = word_t'(100 + i);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      xb.acc_write[3] = 1'b1;
      xb.user_r_rden[3] = 1'b1;
      xb.acc_din[3*DW +: DW] = word_t'(200 + i);
      tick();
    end
    idle();
    xb.user_r_rden[3] = 1'b1;
    repeat (6) tick();
    idle();
    tick();

    // ch0 A2H: close the read file with data and eof pending, then reopen
    for (int i = 0; i < 4; i++) begin
      xb.acc_write[0] = 1'b1;
      xb.acc_din[0 +: DW] = rword();
      xb.acc_done[0] = (i == 3);
      tick();
    end
    idle();
    tick();
    xb.user_r_open[0] = 1'b0;
    repeat (2) tick();
    xb.user_r_open[0] = 1'b1;
    repeat (2) tick();

    // Random traffic with changing rates per block
    for (int blk = 0; blk < 12; blk++) begin
      wp = $urandom_range(0, 100);
      rp = $urandom_range(0, 100);
      repeat (250) random_cycle(wp, rp);
    end
    idle();
    xb.user_w_open = '1;
    xb.user_r_open = '1;
    repeat (2) tick();

    // Reset in the middle of a burst, then a normal write
    repeat (20) random_cycle(70, 30);
    bus_rst = 1'b1;
    random_cycle(70, 30);
    bus_rst = 1'b0;
    idle();
    xb.user_w_open = '1;
    xb.user_r_open = '1;
    tick();
    xb.user_w_wren[0] = 1'b1;
    xb.user_w_data[0 +: DW] = rword();
    tick();
    idle();
    xb.acc_read[0] = 1'b1;
    tick();
    idle();
    repeat (3) tick();

    for (int c = 0; c < NCH; c++) begin
      check("acc_words_left", c, 512'(exp_acc[c].size()), 512'(0));
      check("rd_words_left",  c, 512'(exp_rd[c].size()),  512'(0));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
